// File: rtl/wb_wide_reg_pkg.sv
// wb_wide_reg_pkg
//   Shared constants and helpers for the wide-register Wishbone slave:
//   bus data width, a constant-evaluable clog2, the bus-word to
//   register-word index mapping, and a byte-lane merge.
package wb_wide_reg_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    // Ceiling log2; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Bus word address -> register word index k (word k = bits [32k+31:32k]).
    // Only meaningful for adr < n; callers guard out-of-range addresses.
    function automatic int word_index(input int adr, input int n, input bit msw_first);
        return msw_first ? (n - 1 - adr) : adr;
    endfunction

    // Replace the bytes of old_word whose sel bit is set with new_word's bytes.
    function automatic logic [WB_DATA_W-1:0] byte_merge(
        input logic [WB_DATA_W-1:0] old_word,
        input logic [WB_DATA_W-1:0] new_word,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] res;
        for (int b = 0; b < WB_SEL_W; b++)
            res[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wb_wide_reg_cycle_ctrl.sv
// wb_cycle_ctrl
//   Generic single-outstanding Wishbone handshake: accepts a request,
//   registers address/data/sel/we, and walks it through a fixed
//   three-stage valid pipeline so the ack lands two edges after accept.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cyc, stb, adr, sel, we, dat   bus request inputs
//   ack, stall          bus handshake outputs (both registered/cheap)
//   t1_vld              request is in its first stage (act on next edge = T1)
//   t2_vld              request is in its second stage (act on next edge = T2)
//   req_adr/sel/we/dat  request fields captured at accept
module wb_cycle_ctrl
    import wb_wide_reg_pkg::*;
#(
    parameter int AW = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic [AW-1:0]        adr,
    input  logic [WB_SEL_W-1:0]  sel,
    input  logic                 we,
    input  logic [WB_DATA_W-1:0] dat,
    output logic                 ack,
    output logic                 stall,
    output logic                 t1_vld,
    output logic                 t2_vld,
    output logic [AW-1:0]        req_adr,
    output logic [WB_SEL_W-1:0]  req_sel,
    output logic                 req_we,
    output logic [WB_DATA_W-1:0] req_dat
);

    localparam int STAGES = 2;

    // vld_pipe[0]: accepted, vld_pipe[1]: past T1, vld_pipe[STAGES]: ack cycle
    logic [STAGES:0] vld_pipe;
    logic            busy;
    logic            accept;

    // Busy through the ack cycle: a master holding stb during the ack cycle
    // is still presenting the same request, so it must not be re-accepted.
    assign busy   = |vld_pipe;
    assign accept = cyc & stb & ~busy;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], accept};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_adr <= '0;
            req_sel <= '0;
            req_we  <= 1'b0;
            req_dat <= '0;
        end else if (accept) begin
            req_adr <= adr;
            req_sel <= sel;
            req_we  <= we;
            req_dat <= dat;
        end
    end

    assign ack    = vld_pipe[STAGES];
    assign stall  = cyc & stb & ~ack;
    assign t1_vld = vld_pipe[0];
    assign t2_vld = vld_pipe[1];

endmodule

// File: rtl/wb_wide_reg.sv
// wb_wide_reg
//   Wishbone slave exposing one WIDTH-bit register as N = WIDTH/32 words.
//   ATOMIC=1 adds a write shadow (committed by writing the last bus word)
//   and a read snapshot (captured by reading bus word 0) so multi-word
//   values move coherently. A hardware load port overrides bus updates.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   wb_*_i / wb_*_o               Wishbone pipelined/classic slave port
//   reg_o                         current register value
//   wr_pulse_o                    one-cycle strobe when a bus write lands in reg_o
//   load_i, load_val_i            hardware load (wins over bus updates)
module wb_wide_reg
    import wb_wide_reg_pkg::*;
#(
    parameter int               WIDTH       = 128,
    parameter int               ATOMIC      = 1,
    parameter int               MSW_FIRST   = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              N           = WIDTH / WB_DATA_W,
    localparam int              AW          = (clog2(N) < 1) ? 1 : clog2(N)
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [AW-1:0]        wb_adr_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic                 wb_we_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic                 wb_stall_o,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic [WIDTH-1:0]     reg_o,
    output logic                 wr_pulse_o,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_val_i
);

    localparam bit            POW2       = ((1 << AW) == N);
    localparam logic [AW-1:0] COMMIT_ADR = AW'(N - 1);

    logic [N-1:0][WB_DATA_W-1:0] reg_w, reg_nxt;
    logic [N-1:0][WB_DATA_W-1:0] shadow, shadow_nxt;
    logic [N-1:0][WB_DATA_W-1:0] snap;
    logic [WB_DATA_W-1:0]        rd_q, rd_word;
    logic [WB_DATA_W-1:0]        reg_merged, shadow_merged;
    logic                        pulse_nxt, snap_cap;

    logic                        t1_vld, t2_vld;
    logic [AW-1:0]               req_adr;
    logic [WB_SEL_W-1:0]         req_sel;
    logic                        req_we;
    logic [WB_DATA_W-1:0]        req_dat;

    logic                        in_range;
    logic [AW-1:0]               k_raw, k;

    wb_cycle_ctrl #(.AW(AW)) u_ctrl (
        .clk     (clk_i),
        .rst     (rst_i),
        .cyc     (wb_cyc_i),
        .stb     (wb_stb_i),
        .adr     (wb_adr_i),
        .sel     (wb_sel_i),
        .we      (wb_we_i),
        .dat     (wb_dat_i),
        .ack     (wb_ack_o),
        .stall   (wb_stall_o),
        .t1_vld  (t1_vld),
        .t2_vld  (t2_vld),
        .req_adr (req_adr),
        .req_sel (req_sel),
        .req_we  (req_we),
        .req_dat (req_dat)
    );

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign reg_o    = reg_w;

    // Address holes only exist when N is not a power of two.
    assign in_range = POW2 || ({1'b0, req_adr} < (AW+1)'(N));
    assign k_raw    = AW'(word_index(int'(req_adr), N, MSW_FIRST != 0));
    assign k        = in_range ? k_raw : '0;

    assign reg_merged    = byte_merge(reg_w[k],  req_dat, req_sel);
    assign shadow_merged = byte_merge(shadow[k], req_dat, req_sel);

    // Bus write lands at T2. Commit takes the shadow for all other words and
    // merges the commit word's unselected bytes from the live register.
    // A commit always pulses (it transfers the shadow even with sel = 0).
    always_comb begin
        reg_nxt    = reg_w;
        shadow_nxt = shadow;
        pulse_nxt  = 1'b0;
        if (t2_vld && req_we && in_range) begin
            if (ATOMIC == 0) begin
                reg_nxt[k] = reg_merged;
                pulse_nxt  = |req_sel;
            end else if (req_adr == COMMIT_ADR) begin
                reg_nxt    = shadow;
                reg_nxt[k] = reg_merged;
                pulse_nxt  = 1'b1;
            end else begin
                shadow_nxt[k] = shadow_merged;
            end
        end
        // Hardware load wins; the bus update of this cycle is dropped.
        if (load_i) begin
            reg_nxt   = load_val_i;
            pulse_nxt = 1'b0;
        end
    end

    // Read path sampled at T1. In atomic mode bus word 0 refreshes the
    // snapshot and reads live; every other word reads the snapshot.
    assign snap_cap = t1_vld && !req_we && (ATOMIC != 0) && (req_adr == '0);

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if ((ATOMIC != 0) && (req_adr != '0)) rd_word = snap[k];
            else                                  rd_word = reg_w[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_w      <= RESET_VALUE;
            shadow     <= '0;
            snap       <= '0;
            rd_q       <= '0;
            wb_dat_o   <= '0;
            wr_pulse_o <= 1'b0;
        end else begin
            reg_w      <= reg_nxt;
            shadow     <= shadow_nxt;
            wr_pulse_o <= pulse_nxt;
            if (snap_cap)            snap <= reg_w;
            if (t1_vld && !req_we)   rd_q <= rd_word;
            wb_dat_o <= (t2_vld && !req_we) ? rd_q : '0;
        end
    end

endmodule

// File: doc/wb_wide_reg.md
Name: wb_wide_reg

Overview:
- Parametrised Wishbone (pipelined, classic-compatible) slave holding one register of WIDTH bits, exposed on the bus as N = WIDTH/32 consecutive 32-bit words.
- Next-generation wide-register block: adds generic width, selectable word order, byte-lane writes, and an atomic shadow mode for coherent multi-word access.
- Adds a hardware load port and a commit strobe.
- Sits between the Wishbone interconnect and a peripheral needing wide configuration or status values (timestamps, masks, keys).

Parameters:
- WIDTH, 128, register width in bits; multiple of 32, range 32..1024.
- ATOMIC, 1, 1 = shadowed atomic write and read; 0 = direct per-word access.
- MSW_FIRST, 1, 1 = word address 0 holds bits [WIDTH-1:WIDTH-32]; 0 = word address 0 holds bits [31:0].
- RESET_VALUE, all-zero, WIDTH-bit reset value of the register.
- AW, derived = max(1, clog2(N)), word-address width.

Ports:
- clk_i, in, 1, single clock; all logic on rising edge.
- rst_i, in, 1, synchronous active-high reset.
- wb_cyc_i, in, 1, bus cycle.
- wb_stb_i, in, 1, strobe.
- wb_adr_i, in, AW (bits [AW+1:2]), word address.
- wb_sel_i, in, 4, byte enables, honoured on writes.
- wb_we_i, in, 1, write enable.
- wb_dat_i, in, 32, write data.
- wb_ack_o, out, 1, acknowledge.
- wb_err_o, out, 1, constant 0.
- wb_rty_o, out, 1, constant 0.
- wb_stall_o, out, 1, stall.
- wb_dat_o, out, 32, read data.
- reg_o, out, WIDTH, current register value.
- wr_pulse_o, out, 1, one-cycle strobe when a bus write changes reg_o.
- load_i, in, 1, hardware load request.
- load_val_i, in, WIDTH, value loaded by load_i.

Behaviour:
- Reset (rst_i high at a clock edge): reg_o = RESET_VALUE; write shadow and read snapshot = 0; wb_ack_o = 0; wb_dat_o = 0; wr_pulse_o = 0; in-progress flags cleared.
  - A transaction in flight when reset is asserted is aborted and never acked.
- Transactions:
  - One outstanding transaction at a time.
  - Request accepted at T0 when wb_cyc_i & wb_stb_i and no transaction is in progress.
  - Address, data and sel are registered at T0.
  - wb_ack_o is high for exactly one cycle at T2; wb_dat_o is valid at T2.
  - wb_stall_o = (wb_cyc_i & wb_stb_i) & ~wb_ack_o.
  - Dropping wb_cyc_i after T0 does not cancel the internal operation. The write still takes effect and the ack still pulses; the master ignores it.
- Word mapping: word index k = wb_adr_i when MSW_FIRST = 0, else N-1-wb_adr_i. Word k covers bits [32k+31:32k].
- Out-of-range address (wb_adr_i >= N, only when N is not a power of two): write acked with no effect; read acked with data 0.
- Writes, ATOMIC = 0: bytes of word k with wb_sel_i set update reg_o at T2. wr_pulse_o = 1 at T2 if any sel bit is set.
- Writes, ATOMIC = 1:
  - Commit word = bus word address N-1.
  - A write to any other address updates only the byte lanes of shadow word k.
  - A write to the commit word loads reg_o in one cycle (T2) with the shadow words plus the sel-merged commit word, and pulses wr_pulse_o.
  - The shadow is not cleared by a commit.
  - N = 1 degenerates to a direct write.
- Reads, ATOMIC = 0: return the live word k of reg_o sampled at T1.
- Reads, ATOMIC = 1:
  - A read of bus address 0 captures the whole reg_o into the snapshot at T1 and returns its word.
  - Reads of other addresses return snapshot word k without recapturing.
- Hardware load: load_i at edge E sets reg_o = load_val_i after E. It has priority over a bus update in the same cycle; the bus update is discarded, but its ack still occurs and wr_pulse_o stays 0. Shadow and snapshot are unaffected.
- No combinational path from any bus input to wb_ack_o or wb_dat_o.

Decomposition:
- Package wb_wide_reg_pkg holds:
  - WB_DATA_W = 32;
  - clog2 function;
  - word-index mapping function (adr, N, MSW_FIRST);
  - byte-merge function (old word, new word, sel).
- One sub-module, wb_cycle_ctrl, owns the bus handshake: accept, in-progress flags, request register stage, ack/stall generation. It is reusable across register blocks.
- The top level contains the storage, shadow, snapshot and read mux.

Test Plan (WIDTH=128 unless stated):
- ATOMIC=1, MSW_FIRST=1: write 0x11111111, 0x22222222, 0x33333333 to adr 0,1,2 -> reg_o unchanged, no wr_pulse_o. Write 0x44444444 to adr 3 -> reg_o = 0x11111111_22222222_33333333_44444444 in one cycle, single wr_pulse_o. Ack at T+2 each time.
- ATOMIC=1: reg_o = 0xA..., read adr 0, then load_i with 0xB..., then read adr 1..3 -> all words return the 0xA... snapshot values.
- ATOMIC=0, MSW_FIRST=0: reg_o = 0; write adr 1, data 0xDEADBEEF, sel 4'b0101 -> reg_o[63:32] = 0x00AD00EF, wr_pulse_o high 1 cycle.
- Bus commit and load_i in the same cycle -> reg_o = load_val_i, ack still issued, wr_pulse_o = 0.
- WIDTH=96: read adr 3 -> ack, data 0. Write adr 3 -> ack, reg_o unchanged. Back-to-back strobes -> stall high until each ack, exactly one ack per request.
- Assert rst_i at T1 of a write -> no ack, reg_o = RESET_VALUE; first request after reset acked normally at T+2.
